mc_controller: RTL and testbench

Multicycle MIPS control unit: a Moore FSM that sequences the shared multicycle datapath (one memory for instruction and data, one ALU for PC increment, branch target and execute) over several cycles per instruction. It sits beside the datapath, decodes `op` from the instruction register, and drives every enable and mux select. It supports LW, SW, R-type, BEQ, ADDI and J, and stalls on a memory-ready handshake.

---
 rtl/mc_controller_if.sv | 32 +++
 rtl/mc_controller.sv | 171 +++++++++++++++++
 tb/tb_mc_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle MIPS control unit and its datapath.
// The controller owns every enable/select; the datapath supplies opcode and memory ready.
interface mc_controller_if;
    logic [5:0] op;
    logic       memready;
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, memready,
        output pcwrite, branch, irwrite, memwrite, regwrite, iord, alusrca,
               alusrcb, aluop, pcsrc, regdst, memtoreg, illegal, state
    );

    modport slave (
        output op, memready,
        input  pcwrite, branch, irwrite, memwrite, regwrite, iord, alusrca,
               alusrcb, aluop, pcsrc, regdst, memtoreg, illegal, state
    );
endinterface

// File: rtl/mc_controller.sv
// Moore control FSM for a multicycle MIPS datapath (LW, SW, R-type, BEQ, ADDI, J).
// Outputs decode from the state register, except memready gating in FETCH and reset masking.
module mc_controller (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master ctrl
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;

    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = ctrl.memready ? DECODE : FETCH;
            DECODE: begin
                case (ctrl.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (ctrl.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = ctrl.memready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = ctrl.memready ? FETCH : MEMWR;
            RTYPEEX: state_d = RTYPEWB;
            RTYPEWB: state_d = FETCH;
            BEQEX:   state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JEX:     state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Reset shows the FETCH datapath selects but suppresses every strobe.
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        illegal  = 1'b0;
        if (reset) begin
            alusrcb = 2'b01;
        end else begin
            case (state_q)
                FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = ctrl.memready;
                    pcwrite = ctrl.memready;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    case (ctrl.op)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
                        default:                                       illegal = 1'b1;
                    endcase
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: iord = 1'b1;
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                RTYPEWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                BEQEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                ADDIWB: regwrite = 1'b1;
                JEX: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ctrl.pcwrite  = pcwrite;
    assign ctrl.branch   = branch;
    assign ctrl.irwrite  = irwrite;
    assign ctrl.memwrite = memwrite;
    assign ctrl.regwrite = regwrite;
    assign ctrl.iord     = iord;
    assign ctrl.alusrca  = alusrca;
    assign ctrl.alusrcb  = alusrcb;
    assign ctrl.aluop    = aluop;
    assign ctrl.pcsrc    = pcsrc;
    assign ctrl.regdst   = regdst;
    assign ctrl.memtoreg = memtoreg;
    assign ctrl.illegal  = illegal;
    assign ctrl.state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each driven cycle queues the full expected output
// vector for the state the instruction should be in; the negedge monitor pops and compares.
module tb_mc_controller;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    typedef struct {
        string       tag;
        logic [19:0] expected;
    } exp_t;

    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;
    exp_t expQ[$];

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packing order: state, pcwrite, branch, irwrite, memwrite, regwrite, iord, alusrca,
    // alusrcb, aluop, pcsrc, regdst, memtoreg, illegal.
    function automatic logic [19:0] expOut(int st, bit mr, bit rst, logic [5:0] op);
        logic pw, br, irw, mw, rw, io, asa, rd, m2r, ill;
        logic [1:0] asb, aop, ps;
        pw = 0; br = 0; irw = 0; mw = 0; rw = 0; io = 0; asa = 0;
        rd = 0; m2r = 0; ill = 0; asb = 2'b00; aop = 2'b00; ps = 2'b00;
        if (rst) begin
            asb = 2'b01;
        end else begin
            case (st)
                0:  begin asb = 2'b01; irw = mr; pw = mr; end
                1:  begin
                        asb = 2'b11;
                        ill = !(op == OP_LW || op == OP_SW || op == OP_RTYPE ||
                                op == OP_BEQ || op == OP_ADDI || op == OP_J);
                    end
                2:  begin asa = 1; asb = 2'b10; end
                3:  io = 1;
                4:  begin m2r = 1; rw = 1; end
                5:  begin io = 1; mw = 1; end
                6:  begin asa = 1; aop = 2'b10; end
                7:  begin rd = 1; rw = 1; end
                8:  begin asa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
                9:  begin asa = 1; asb = 2'b10; end
                10: rw = 1;
                11: begin ps = 2'b10; pw = 1; end
                default: ;
            endcase
        end
        return {4'(st), pw, br, irw, mw, rw, io, asa, asb, aop, ps, rd, m2r, ill};
    endfunction

    task automatic checkOutput(string tag, logic [31:0] actual, logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%05h, expected 0x%05h", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs just after the edge and queue what the outputs must be.
    task automatic applyStimulus(string tag, logic [5:0] op, bit mr, bit rst, int st);
        exp_t e;
        @(posedge clk);
        #1;
        bus.op       = op;
        bus.memready = mr;
        reset        = rst;
        e.tag        = tag;
        e.expected   = expOut(st, mr, rst, op);
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput(e.tag, 32'({bus.state, bus.pcwrite, bus.branch, bus.irwrite,
                                    bus.memwrite, bus.regwrite, bus.iord, bus.alusrca,
                                    bus.alusrcb, bus.aluop, bus.pcsrc, bus.regdst,
                                    bus.memtoreg, bus.illegal}),
                        32'(e.expected));
        end
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset        = 1'b1;
        bus.op       = OP_LW;
        bus.memready = 1'b1;

        applyStimulus("reset", OP_LW, 1, 1, 0);

        // LW with memory always ready: 0,1,2,3,4
        applyStimulus("lw fetch",  OP_LW, 1, 0, 0);
        applyStimulus("lw decode", OP_LW, 1, 0, 1);
        applyStimulus("lw memadr", OP_LW, 1, 0, 2);
        applyStimulus("lw memrd",  OP_LW, 1, 0, 3);
        applyStimulus("lw memwb",  OP_LW, 1, 0, 4);

        // SW stalled three cycles in MEMWR
        applyStimulus("sw fetch",  OP_SW, 1, 0, 0);
        applyStimulus("sw decode", OP_SW, 1, 0, 1);
        applyStimulus("sw memadr", OP_SW, 1, 0, 2);
        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("sw stall%0d", i), OP_SW, 0, 0, 5);
        applyStimulus("sw memwr", OP_SW, 1, 0, 5);

        // R-type, BEQ, J back to back
        applyStimulus("r fetch",    OP_RTYPE, 1, 0, 0);
        applyStimulus("r decode",   OP_RTYPE, 1, 0, 1);
        applyStimulus("r ex",       OP_RTYPE, 1, 0, 6);
        applyStimulus("r wb",       OP_RTYPE, 1, 0, 7);
        applyStimulus("beq fetch",  OP_BEQ,   1, 0, 0);
        applyStimulus("beq decode", OP_BEQ,   1, 0, 1);
        applyStimulus("beq ex",     OP_BEQ,   1, 0, 8);
        applyStimulus("j fetch",    OP_J,     1, 0, 0);
        applyStimulus("j decode",   OP_J,     1, 0, 1);
        applyStimulus("j ex",       OP_J,     1, 0, 11);

        // FETCH stall for two cycles, then a J
        applyStimulus("fstall0",   OP_J, 0, 0, 0);
        applyStimulus("fstall1",   OP_J, 0, 0, 0);
        applyStimulus("fstall go", OP_J, 1, 0, 0);
        applyStimulus("fstall dc", OP_J, 1, 0, 1);
        applyStimulus("fstall jx", OP_J, 1, 0, 11);

        // Unsupported opcode
        applyStimulus("ill fetch",  OP_BAD, 1, 0, 0);
        applyStimulus("ill decode", OP_BAD, 1, 0, 1);
        applyStimulus("ill after",  OP_BAD, 1, 0, 0);
        applyStimulus("ill decode2", OP_LW, 1, 0, 1);
        applyStimulus("ill memadr", OP_LW, 1, 0, 2);

        // Reset while LW waits in MEMRD, then ADDI
        applyStimulus("rrd memrd", OP_LW, 0, 0, 3);
        applyStimulus("rrd reset", OP_LW, 0, 1, 3);
        applyStimulus("addi fetch",  OP_ADDI, 1, 0, 0);
        applyStimulus("addi decode", OP_ADDI, 1, 0, 1);
        applyStimulus("addi ex",     OP_ADDI, 1, 0, 9);
        applyStimulus("addi wb",     OP_ADDI, 1, 0, 10);

        // Reset while SW waits in MEMWR drops the write strobe
        applyStimulus("rwr fetch",  OP_SW, 1, 0, 0);
        applyStimulus("rwr decode", OP_SW, 1, 0, 1);
        applyStimulus("rwr memadr", OP_SW, 1, 0, 2);
        applyStimulus("rwr memwr",  OP_SW, 0, 0, 5);
        applyStimulus("rwr reset",  OP_SW, 0, 1, 5);
        applyStimulus("rwr after",  OP_SW, 0, 0, 0);
        applyStimulus("rwr stall",  OP_SW, 0, 0, 0);

        repeat (2) @(posedge clk);
        checkOutput("drain", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
